draw_scheduler: RTL
===================

Name: draw_scheduler

Overview:
Frame-level controller that sequences the two drawing engines (screen fill and Reuleaux triangle) and shares the single VGA adapter plot port between them. On start it clears the screen to a background colour, then draws up to NUM_SHAPES Reuleaux triangles from an internal slot table. Sits between the top level and the engines, replacing direct top-level wiring of engine start/done and vga_* signals.

Parameters:
NUM_SHAPES, 4, number of shape slots (slot index width = clog2(NUM_SHAPES), min 1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  write slot cfg_idx (ignored while busy=1)
cfg_idx  in  clog2(NUM_SHAPES)  slot index
cfg_en  in  1  slot enable
cfg_centre_x  in  8  slot centre x
cfg_centre_y  in  7  slot centre y
cfg_diameter  in  8  slot diameter
cfg_colour  in  3  slot colour
bg_colour  in  3  fill colour, sampled when start accepted
start  in  1  frame request (level, held until done)
done  out  1  frame complete
busy  out  1  high from start acceptance until DONE entered
fill_start  out  1  fill engine start
fill_colour  out  3  latched bg_colour
fill_done  in  1  fill engine done
fill_vga_x/fill_vga_y/fill_vga_colour/fill_vga_plot  in  8/7/3/1  fill engine pixel
reul_start  out  1  Reuleaux engine start
reul_centre_x/reul_centre_y/reul_diameter/reul_colour  out  8/7/8/3  current slot fields (registered)
reul_done  in  1  Reuleaux engine done
reul_vga_x/reul_vga_y/reul_vga_colour/reul_vga_plot  in  8/7/3/1  Reuleaux engine pixel
vga_x/vga_y/vga_colour/vga_plot  out  8/7/3/1  to VGA adapter

Behaviour:
- Reset: state IDLE; done, busy, fill_start, reul_start, vga_plot = 0; slot index 0; all slot enables cleared; other outputs 0. Reset mid-frame aborts: starts drop at the next edge, no further plots.
- Engine handshake: scheduler holds X_start high until X_done=1 is sampled, drops X_start next cycle, then waits for X_done=0 before moving on (engines keep done high while start high).
- States: IDLE -> FILL_RUN -> FILL_REL -> SCAN -> SHAPE_RUN -> SHAPE_REL -> SCAN ... -> DONE.
- IDLE: start=1 sampled -> latch bg_colour, slot=0, busy=1; fill_start=1 on the following cycle (1-cycle latency).
- FILL_RUN: fill_start=1; on fill_done -> FILL_REL (fill_start=0). FILL_REL: fill_done=0 -> SCAN.
- SCAN (1 cycle per slot): slot past NUM_SHAPES-1 -> DONE. Slot enabled and diameter!=0 -> load reul_* from slot, SHAPE_RUN. Otherwise slot+1, stay SCAN.
- SHAPE_RUN: reul_start=1; on reul_done -> SHAPE_REL. SHAPE_REL: reul_done=0 -> slot+1, SCAN.
- DONE: done=1, busy=0; held while start=1; start=0 -> IDLE, done=0 next cycle. Restart requires start low for at least 1 cycle.
- VGA mux (combinational): FILL_RUN -> fill_vga_*; SHAPE_RUN -> reul_vga_*; all other states vga_plot=0, vga_x/y/colour=0. Plots from the non-selected engine are discarded.
- Config: writes in IDLE or DONE take effect for the next frame; cfg_we while busy is ignored. A write to the slot being drawn never disturbs reul_* mid-shape.
- No slots enabled: frame = fill only; done follows FILL_REL + NUM_SHAPES SCAN cycles.
- Engine done already high on entry to a RUN state: treated as completion (no deadlock).

Test Plan:
- Reset then start=1, no slots enabled, bg_colour=3'b000 -> fill_start rises 1 cycle after start; reul_start never asserts; done=1 after fill_done handshake + 4 SCAN cycles; vga_plot mirrors fill_vga_plot only.
- Slot0 {80,60,80,3'b010} enabled, start -> fill completes, then reul_start with reul_centre_x=80, reul_centre_y=60, reul_diameter=80, reul_colour=3'b010; done after reul_done handshake.
- Slots 0 and 2 enabled, slot 3 diameter 0 enabled -> exactly two reul_start pulses in order slot0, slot2; slot3 skipped.
- Inject reul_vga_plot=1 during FILL_RUN and fill_vga_plot=1 during SHAPE_RUN -> vga_plot stays 0 in both cases.
- cfg_we on slot1 while busy -> table unchanged this frame and next; same write in DONE -> used next frame.
- Assert rst during SHAPE_RUN -> next edge: reul_start=0, busy=0, done=0, vga_plot=0, state IDLE; slot enables cleared.

Source files
------------

// File: rtl/draw_scheduler.sv
// Frame sequencer: clears the screen with the fill engine, then draws each enabled
// Reuleaux slot in turn, muxing the active engine onto the single VGA plot port.
module draw_scheduler #(
   parameter  int NUM_SHAPES = 4,
   localparam int IDX_W      = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [7:0]       cfg_centre_x,
   input  logic [6:0]       cfg_centre_y,
   input  logic [7:0]       cfg_diameter,
   input  logic [2:0]       cfg_colour,
   input  logic [2:0]       bg_colour,
   input  logic             start,
   output logic             done,
   output logic             busy,
   output logic             fill_start,
   output logic [2:0]       fill_colour,
   input  logic             fill_done,
   input  logic [7:0]       fill_vga_x,
   input  logic [6:0]       fill_vga_y,
   input  logic [2:0]       fill_vga_colour,
   input  logic             fill_vga_plot,
   output logic             reul_start,
   output logic [7:0]       reul_centre_x,
   output logic [6:0]       reul_centre_y,
   output logic [7:0]       reul_diameter,
   output logic [2:0]       reul_colour,
   input  logic             reul_done,
   input  logic [7:0]       reul_vga_x,
   input  logic [6:0]       reul_vga_y,
   input  logic [2:0]       reul_vga_colour,
   input  logic             reul_vga_plot,
   output logic [7:0]       vga_x,
   output logic [6:0]       vga_y,
   output logic [2:0]       vga_colour,
   output logic             vga_plot
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FILL_RUN  = 3'd1;
   localparam logic [2:0] S_FILL_REL  = 3'd2;
   localparam logic [2:0] S_SCAN      = 3'd3;
   localparam logic [2:0] S_SHAPE_RUN = 3'd4;
   localparam logic [2:0] S_SHAPE_REL = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   // Slot counter carries one extra bit so "past the last slot" is representable.
   localparam logic [IDX_W:0] SLOT_END  = (IDX_W+1)'(NUM_SHAPES);
   localparam logic [IDX_W:0] SLOT_LAST = (IDX_W+1)'(NUM_SHAPES - 1);
   localparam logic [IDX_W:0] SLOT_ONE  = (IDX_W+1)'(1);

   logic [2:0]       state_q, state_d;
   logic [IDX_W:0]   slot_q, slot_d;
   logic [2:0]       bg_q, bg_d;
   logic             load_shape;
   logic             busy_w;
   logic             cfg_wr;
   logic [IDX_W-1:0] slot_idx;

   logic [NUM_SHAPES-1:0] en_q;
   logic [7:0]            tab_x_q   [NUM_SHAPES];
   logic [6:0]            tab_y_q   [NUM_SHAPES];
   logic [7:0]            tab_dia_q [NUM_SHAPES];
   logic [2:0]            tab_col_q [NUM_SHAPES];

   logic [7:0] rx_q, rdia_q;
   logic [6:0] ry_q;
   logic [2:0] rcol_q;

   assign busy_w   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign slot_idx = slot_q[IDX_W-1:0];
   assign cfg_wr   = cfg_we && !busy_w && ({1'b0, cfg_idx} < SLOT_END);

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      bg_d       = bg_q;
      load_shape = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL_RUN;
               slot_d  = '0;
               bg_d    = bg_colour;
            end
         end
         S_FILL_RUN:  if (fill_done)  state_d = S_FILL_REL;
         S_FILL_REL:  if (!fill_done) state_d = S_SCAN;
         S_SCAN: begin
            if (slot_q >= SLOT_END) begin
               state_d = S_DONE;
            end else if (en_q[slot_idx] && (tab_dia_q[slot_idx] != 8'd0)) begin
               load_shape = 1'b1;
               state_d    = S_SHAPE_RUN;
            end else if (slot_q == SLOT_LAST) begin
               state_d = S_DONE;
            end else begin
               slot_d = slot_q + SLOT_ONE;
            end
         end
         S_SHAPE_RUN: if (reul_done) state_d = S_SHAPE_REL;
         S_SHAPE_REL: begin
            if (!reul_done) begin
               slot_d  = slot_q + SLOT_ONE;
               state_d = S_SCAN;
            end
         end
         S_DONE:      if (!start) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         bg_q    <= 3'd0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         bg_q    <= bg_d;
         if (cfg_wr) en_q[cfg_idx] <= cfg_en;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_wr) begin
         tab_x_q[cfg_idx]   <= cfg_centre_x;
         tab_y_q[cfg_idx]   <= cfg_centre_y;
         tab_dia_q[cfg_idx] <= cfg_diameter;
         tab_col_q[cfg_idx] <= cfg_colour;
      end
   end

   // Shape fields are captured once per shape so the engine sees stable inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q   <= 8'd0;
         ry_q   <= 7'd0;
         rdia_q <= 8'd0;
         rcol_q <= 3'd0;
      end else if (load_shape) begin
         rx_q   <= tab_x_q[slot_idx];
         ry_q   <= tab_y_q[slot_idx];
         rdia_q <= tab_dia_q[slot_idx];
         rcol_q <= tab_col_q[slot_idx];
      end
   end

   assign done          = (state_q == S_DONE);
   assign busy          = busy_w;
   assign fill_start    = (state_q == S_FILL_RUN);
   assign reul_start    = (state_q == S_SHAPE_RUN);
   assign fill_colour   = bg_q;
   assign reul_centre_x = rx_q;
   assign reul_centre_y = ry_q;
   assign reul_diameter = rdia_q;
   assign reul_colour   = rcol_q;

   always_comb begin
      vga_x      = 8'd0;
      vga_y      = 7'd0;
      vga_colour = 3'd0;
      vga_plot   = 1'b0;
      if (state_q == S_FILL_RUN) begin
         vga_x      = fill_vga_x;
         vga_y      = fill_vga_y;
         vga_colour = fill_vga_colour;
         vga_plot   = fill_vga_plot;
      end else if (state_q == S_SHAPE_RUN) begin
         vga_x      = reul_vga_x;
         vga_y      = reul_vga_y;
         vga_colour = reul_vga_colour;
         vga_plot   = reul_vga_plot;
      end
   end

endmodule
